// File: rtl/mod_hi_speed_protocol_decoder.sv
// Receive-side frame decoder for the high-speed RS-485 link: parses MARKER/FLAG/LEN/data/CRC
// frames from the byte receiver, writes data bytes to the RX RAM and reports each frame once.
module mod_hi_speed_protocol_decoder #(
    parameter logic [7:0]  MARKER_BYTE = 8'hB6,
    parameter logic [15:0] MAX_LEN     = 16'd4096,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2400
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic        RX_PARITY_ERR,
    output logic        RX_RAM_REQ_WR,
    input  logic        RX_RAM_RDY_WR,
    output logic [15:0] RX_RAM_ADDR_OUT,
    output logic [7:0]  RX_RAM_DATA_OUT,
    output logic        DECODING,
    output logic        RX_STR,
    output logic [7:0]  RX_FLAG,
    output logic [15:0] RX_BYTE_NUMBER,
    output logic [3:0]  RX_ERR
);
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [2:0] {
        S_IDLE, S_FLAG, S_LEN_H, S_LEN_L, S_DATA, S_CRC_H, S_CRC_L, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_crc, r_len, r_rxCnt, r_addr, r_outNum;
    logic [7:0]  r_flag, r_crcH, r_ramData, r_outFlag;
    logic [3:0]  r_err, r_outErr;
    logic [23:0] r_toCnt;
    logic        r_reqWr, r_decoding, r_rxStr;

    logic        w_markerOk, w_inFrame, w_timeout, w_abortTo, w_reqFree, w_allRx;
    logic [15:0] w_lenIn;

    // CRC16, polynomial 0x1021, MSB first, one byte per call
    function automatic logic [15:0] crcNext(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        return r;
    endfunction

    assign w_markerOk = RX_VALID && (RX_DATA == MARKER_BYTE) && !RX_PARITY_ERR;
    assign w_inFrame  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_timeout  = (r_toCnt >= TIMEOUT_CYC);
    assign w_abortTo  = w_inFrame && w_timeout && !r_reqWr;
    assign w_reqFree  = !r_reqWr || RX_RAM_RDY_WR;
    assign w_allRx    = (r_rxCnt == r_len);
    assign w_lenIn    = {r_len[15:8], RX_DATA};

    assign RX_RAM_REQ_WR   = r_reqWr;
    assign RX_RAM_ADDR_OUT = r_addr;
    assign RX_RAM_DATA_OUT = r_ramData;
    assign DECODING        = r_decoding;
    assign RX_STR          = r_rxStr;
    assign RX_FLAG         = r_outFlag;
    assign RX_BYTE_NUMBER  = r_outNum;
    assign RX_ERR          = r_outErr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A CRC_H byte arriving while the last data write is still in flight skips CRC_H
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_markerOk) w_next = S_FLAG;
            S_FLAG:  if (RX_VALID) w_next = S_LEN_H;
            S_LEN_H: if (RX_VALID) w_next = S_LEN_L;
            S_LEN_L: if (RX_VALID) begin
                         if (w_lenIn == 16'd0)     w_next = S_CRC_H;
                         else if (w_lenIn > MAX_LEN) w_next = S_DONE;
                         else                        w_next = S_DATA;
                     end
            S_DATA:  if (w_allRx) begin
                         if (RX_VALID)      w_next = S_CRC_L;
                         else if (!r_reqWr) w_next = S_CRC_H;
                     end
            S_CRC_H: if (RX_VALID) w_next = S_CRC_L;
            S_CRC_L: if (RX_VALID) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abortTo) w_next = S_DONE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_crc      <= CRC_INIT;
            r_len      <= '0;
            r_rxCnt    <= '0;
            r_addr     <= '0;
            r_flag     <= '0;
            r_crcH     <= '0;
            r_ramData  <= '0;
            r_err      <= '0;
            r_toCnt    <= '0;
            r_reqWr    <= 1'b0;
            r_decoding <= 1'b0;
            r_rxStr    <= 1'b0;
            r_outFlag  <= '0;
            r_outNum   <= '0;
            r_outErr   <= '0;
        end else begin
            r_rxStr <= 1'b0;
            if (r_reqWr && RX_RAM_RDY_WR) begin
                r_reqWr <= 1'b0;
                r_addr  <= r_addr + 16'd1;
            end
            if (!w_inFrame || RX_VALID) r_toCnt <= '0;
            else if (!w_timeout)        r_toCnt <= r_toCnt + 24'd1;
            if (w_abortTo) r_err[2] <= 1'b1;
            else if (w_inFrame && RX_VALID && RX_PARITY_ERR) r_err[1] <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_crc <= CRC_INIT;
                    if (w_markerOk) begin
                        r_crc      <= crcNext(CRC_INIT, RX_DATA);
                        r_decoding <= 1'b1;
                        r_err      <= '0;
                        r_addr     <= '0;
                        r_rxCnt    <= '0;
                    end
                end
                S_FLAG: if (RX_VALID && !w_abortTo) begin
                    r_flag <= RX_DATA;
                    r_crc  <= crcNext(r_crc, RX_DATA);
                end
                S_LEN_H: if (RX_VALID && !w_abortTo) begin
                    r_len[15:8] <= RX_DATA;
                    r_crc       <= crcNext(r_crc, RX_DATA);
                end
                S_LEN_L: if (RX_VALID && !w_abortTo) begin
                    r_len[7:0] <= RX_DATA;
                    r_crc      <= crcNext(r_crc, RX_DATA);
                    if (w_lenIn > MAX_LEN) r_err[3] <= 1'b1;
                end
                // Overrun bytes are still part of the frame: they count and feed the CRC
                S_DATA: if (RX_VALID && !w_abortTo) begin
                    if (!w_allRx) begin
                        r_crc   <= crcNext(r_crc, RX_DATA);
                        r_rxCnt <= r_rxCnt + 16'd1;
                        if (w_reqFree) begin
                            r_ramData <= RX_DATA;
                            r_reqWr   <= 1'b1;
                        end else begin
                            r_err[3] <= 1'b1;
                        end
                    end else begin
                        r_crcH <= RX_DATA;
                    end
                end
                S_CRC_H: if (RX_VALID && !w_abortTo) r_crcH <= RX_DATA;
                S_CRC_L: if (RX_VALID && !w_abortTo && ({r_crcH, RX_DATA} != r_crc)) r_err[0] <= 1'b1;
                S_DONE: begin
                    r_rxStr    <= 1'b1;
                    r_decoding <= 1'b0;
                    r_crc      <= CRC_INIT;
                    r_outFlag  <= r_flag;
                    r_outNum   <= r_len;
                    r_outErr   <= r_err;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_hi_speed_protocol_decoder.sv
// Self-checking bench for mod_hi_speed_protocol_decoder: directed frames plus random frames
// checked against a bit-serial CRC16 reference and a frame-level outcome model.
module tb_mod_hi_speed_protocol_decoder;
    typedef logic [7:0] byteQ_t[$];

    localparam logic [7:0] MARKER = 8'hB6;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RX_PARITY_ERR = 1'b0;
    logic        RX_RAM_REQ_WR;
    logic        RX_RAM_RDY_WR = 1'b0;
    logic [15:0] RX_RAM_ADDR_OUT;
    logic [7:0]  RX_RAM_DATA_OUT;
    logic        DECODING;
    logic        RX_STR;
    logic [7:0]  RX_FLAG;
    logic [15:0] RX_BYTE_NUMBER;
    logic [3:0]  RX_ERR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lastValidCyc = 0;
    bit ramEnable = 1'b1;

    logic [15:0] wrAddr[$];
    logic [7:0]  wrData[$];
    logic [7:0]  stFlag[$];
    logic [15:0] stNum[$];
    logic [3:0]  stErr[$];
    logic        stDec[$];
    int          stCyc[$];

    mod_hi_speed_protocol_decoder dut (
        .CLK(CLK),
        .RESET(RESET),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_PARITY_ERR(RX_PARITY_ERR),
        .RX_RAM_REQ_WR(RX_RAM_REQ_WR),
        .RX_RAM_RDY_WR(RX_RAM_RDY_WR),
        .RX_RAM_ADDR_OUT(RX_RAM_ADDR_OUT),
        .RX_RAM_DATA_OUT(RX_RAM_DATA_OUT),
        .DECODING(DECODING),
        .RX_STR(RX_STR),
        .RX_FLAG(RX_FLAG),
        .RX_BYTE_NUMBER(RX_BYTE_NUMBER),
        .RX_ERR(RX_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model: acknowledges a pending request with a one-cycle RDY and logs the write
    initial begin
        forever begin
            @(negedge CLK);
            if (RX_RAM_REQ_WR === 1'b1 && ramEnable && !RX_RAM_RDY_WR) begin
                wrAddr.push_back(RX_RAM_ADDR_OUT);
                wrData.push_back(RX_RAM_DATA_OUT);
                RX_RAM_RDY_WR = 1'b1;
            end else begin
                RX_RAM_RDY_WR = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RX_STR === 1'b1) begin
                stFlag.push_back(RX_FLAG);
                stNum.push_back(RX_BYTE_NUMBER);
                stErr.push_back(RX_ERR);
                stDec.push_back(DECODING);
                stCyc.push_back(cyc);
            end
        end
    end

    // Reference CRC: shift-register division one message bit at a time
    function automatic logic [15:0] refCrc(input byteQ_t q);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ q[i][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic byteQ_t buildFrame(input logic [7:0] flag, input byteQ_t data,
                                          input logic [15:0] crcXor);
        byteQ_t      q;
        logic [15:0] len;
        logic [15:0] crc;
        len = 16'(data.size());
        q.push_back(MARKER);
        q.push_back(flag);
        q.push_back(len[15:8]);
        q.push_back(len[7:0]);
        foreach (data[i]) q.push_back(data[i]);
        crc = refCrc(q) ^ crcXor;
        q.push_back(crc[15:8]);
        q.push_back(crc[7:0]);
        return q;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; leaves the bench on a negedge
    task automatic sendByte(input logic [7:0] b, input logic par, input int gap);
        RX_DATA       = b;
        RX_VALID      = 1'b1;
        RX_PARITY_ERR = par;
        lastValidCyc  = cyc;
        @(negedge CLK);
        RX_VALID      = 1'b0;
        RX_PARITY_ERR = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic [7:0] flag, input byteQ_t data,
                                 input logic [15:0] crcXor, input int parIdx);
        byteQ_t q;
        q = buildFrame(flag, data, crcXor);
        foreach (q[i]) sendByte(q[i], (i == parIdx), int'($urandom_range(3, 1)));
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] eFlag, input logic [15:0] eNum,
                              input logic [3:0] eErr, input byteQ_t eData, input bit latChk);
        int n;
        for (int i = 0; i < 200 && stFlag.size() == 0; i++) @(negedge CLK);
        repeat (4) @(negedge CLK);
        checkOutput({tag, "_strobes"}, stFlag.size(), 1);
        if (stFlag.size() > 0) begin
            checkOutput({tag, "_flag"}, 32'(stFlag[0]), 32'(eFlag));
            checkOutput({tag, "_num"}, 32'(stNum[0]), 32'(eNum));
            checkOutput({tag, "_err"}, 32'(stErr[0]), 32'(eErr));
            checkOutput({tag, "_decoding"}, 32'(stDec[0]), 0);
            if (latChk) checkOutput({tag, "_latency"}, stCyc[0] - lastValidCyc, 2);
        end
        checkOutput({tag, "_writes"}, wrAddr.size(), eData.size());
        n = (wrAddr.size() < eData.size()) ? wrAddr.size() : eData.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_addr"}, 32'(wrAddr[i]), i);
            checkOutput({tag, "_data"}, 32'(wrData[i]), 32'(eData[i]));
        end
        wrAddr.delete(); wrData.delete();
        stFlag.delete(); stNum.delete(); stErr.delete(); stDec.delete(); stCyc.delete();
    endtask

    initial begin
        byteQ_t d;
        byteQ_t f;
        byteQ_t e;
        logic [15:0] x;
        int p;

        repeat (3) @(negedge CLK);
        checkOutput("reset_ctrl", {DECODING, RX_STR, RX_RAM_REQ_WR, RX_RAM_ADDR_OUT, RX_RAM_DATA_OUT}, 0);
        checkOutput("reset_report", {RX_FLAG, RX_BYTE_NUMBER, RX_ERR}, 0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        d = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h21, d, 16'h0000, -1);
        checkFrame("good", 8'h21, 16'd3, 4'b0000, d, 1'b1);

        d = {};
        applyStimulus(8'h05, d, 16'h0000, -1);
        checkFrame("len0", 8'h05, 16'd0, 4'b0000, d, 1'b1);

        d = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h21, d, 16'h00FF, -1);
        checkFrame("badcrc", 8'h21, 16'd3, 4'b0001, d, 1'b1);

        sendByte(8'h00, 1'b0, 2);
        sendByte(8'hFF, 1'b0, 2);
        d = '{8'hC4, 8'hB6};
        applyStimulus(8'h3C, d, 16'h0000, -1);
        checkFrame("junk", 8'h3C, 16'd2, 4'b0000, d, 1'b1);

        d = '{8'hA0, 8'hA1, 8'hA2};
        f = buildFrame(8'h55, d, 16'h0000);
        for (int i = 0; i < 6; i++) sendByte(f[i], 1'b0, 2);
        repeat (2600) @(negedge CLK);
        e = '{8'hA0, 8'hA1};
        checkFrame("timeout", 8'h55, 16'd3, 4'b0100, e, 1'b0);
        checkOutput("timeout_decoding", 32'(DECODING), 0);
        applyStimulus(8'h56, d, 16'h0000, -1);
        checkFrame("after_to", 8'h56, 16'd3, 4'b0000, d, 1'b1);

        d = '{8'hD0, 8'hD1, 8'hD2};
        f = buildFrame(8'h44, d, 16'h0000);
        for (int i = 0; i < 4; i++) sendByte(f[i], 1'b0, 2);
        ramEnable = 1'b0;
        sendByte(f[4], 1'b0, 2);
        sendByte(f[5], 1'b0, 3);
        ramEnable = 1'b1;
        repeat (3) @(negedge CLK);
        for (int i = 6; i < 9; i++) sendByte(f[i], 1'b0, 2);
        e = '{8'hD0, 8'hD2};
        checkFrame("overrun", 8'h44, 16'd3, 4'b1000, e, 1'b1);

        d = '{8'hE1, 8'hE2};
        f = buildFrame(8'h66, d, 16'h0000);
        for (int i = 0; i < 4; i++) sendByte(f[i], 1'b0, 2);
        sendByte(f[4], 1'b0, 0);
        sendByte(f[5], 1'b0, 3);
        sendByte(f[6], 1'b0, 2);
        sendByte(f[7], 1'b0, 2);
        checkFrame("simul_rdy", 8'h66, 16'd2, 4'b0000, d, 1'b1);

        sendByte(MARKER, 1'b0, 2);
        sendByte(8'h77, 1'b0, 2);
        sendByte(8'hFF, 1'b0, 2);
        sendByte(8'hFF, 1'b0, 2);
        e = {};
        checkFrame("maxlen", 8'h77, 16'hFFFF, 4'b1000, e, 1'b0);

        sendByte(MARKER, 1'b0, 2);
        sendByte(8'h33, 1'b0, 2);
        checkOutput("midrst_before", 32'(DECODING), 1);
        RESET = 1'b0;
        #1;
        checkOutput("midrst_decoding", 32'(DECODING), 0);
        checkOutput("midrst_flag", 32'(RX_FLAG), 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (6) @(negedge CLK);
        checkOutput("midrst_nostrobe", stFlag.size(), 0);

        for (int t = 0; t < 20; t++) begin
            d = {};
            for (int i = 0; i < int'($urandom_range(6, 0)); i++) d.push_back(8'($urandom));
            x = ($urandom_range(9, 0) < 3) ? 16'($urandom_range(65535, 1)) : 16'h0000;
            p = ($urandom_range(9, 0) < 3) ? int'($urandom_range(d.size() + 5, 1)) : -1;
            applyStimulus(8'(t * 7 + 1), d, x, p);
            checkFrame("random", 8'(t * 7 + 1), 16'(d.size()),
                       {2'b00, (p >= 0), (x != 16'h0000)}, d, 1'b1);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
